tournament_pred_pipe: RTL and testbench

- Parametrised next-generation tournament branch predictor: gshare and pshare components arbitrated by a per-PC chooser, all sized by parameters.
- Sits between fetch and branch resolution.
- Accepts one lookup (PC plus decoded target `etiqueta`) through a ready/valid handshake, returns a registered prediction and `nex_PC`, and holds one branch in flight until the resolved outcome (`fix_result`) trains all tables.

---
 rtl/tournament_pred_pipe.sv | 200 ++++++++++++++++++++
 tb/tb_tournament_pred_pipe.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/tournament_pred_pipe.sv
// rtl/tournament_pred_pipe.sv - tournament branch predictor (gshare + pshare + chooser), one branch in flight
//
// Purpose: accepts one lookup (PC, etiqueta) through valid/ready, registers a
// prediction and nex_PC one cycle later, and keeps the lookup record until the
// resolved outcome arrives on upd_valid/fix_result to train all tables.
//
// Optional feature: define TOURN_STATS_EN to add the stat_lookups/stat_miss counters.
//
// Ports:
//   clock, reset        - rising-edge clock, asynchronous active-low reset
//   valid, PC, etiqueta - lookup request: branch address and decoded target
//   ready               - lookup accepted this cycle when valid & ready
//   pred_valid          - prediction/nex_PC are valid (branch in flight)
//   prediction, nex_PC  - predicted direction (1 = taken), predicted next fetch address
//   upd_valid, fix_result - resolution of the in-flight branch, actual outcome
//   mispredict          - one-cycle pulse after a wrong resolution
//   stat_lookups, stat_miss - saturating counters (TOURN_STATS_EN only)
module tournament_pred_pipe #(
  parameter int n        = 32,
  parameter int IDX_BITS = 4,
  parameter int GHR_BITS = 4,
  parameter int LHR_BITS = 4,
  parameter int CTR_BITS = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         valid,
  input  logic [n-1:0] PC,
  input  logic [n-1:0] etiqueta,
  output logic         ready,
  output logic         pred_valid,
  output logic         prediction,
  output logic [n-1:0] nex_PC,
  input  logic         upd_valid,
  input  logic         fix_result,
  output logic         mispredict
`ifdef TOURN_STATS_EN
  ,
  output logic [31:0]  stat_lookups,
  output logic [31:0]  stat_miss
`endif
);

  localparam int IDX_N = 1 << IDX_BITS;
  localparam int GHR_N = 1 << GHR_BITS;
  localparam int LHR_N = 1 << LHR_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t state_q, state_d;

  logic [CTR_BITS-1:0] gpht_q    [GHR_N];
  logic [CTR_BITS-1:0] ppht_q    [LHR_N];
  logic [1:0]          chooser_q [IDX_N];
  logic [LHR_BITS-1:0] lht_q     [IDX_N];
  logic [GHR_BITS-1:0] ghr_q;

  // Latched record of the in-flight branch
  logic [IDX_BITS-1:0] ci_q;
  logic [GHR_BITS-1:0] gi_q;
  logic [LHR_BITS-1:0] pi_q;
  logic                pg_q, pp_q;

  logic                pred_valid_q, prediction_q, mispredict_q;
  logic [n-1:0]        nex_pc_q;

  logic                accept, do_upd;
  logic [IDX_BITS-1:0] ci_w;
  logic [GHR_BITS-1:0] gi_w;
  logic [LHR_BITS-1:0] pi_w;
  logic                pg_w, pp_w, sel_w, pred_w;
  logic [n-1:0]        nex_w;

  function automatic logic [CTR_BITS-1:0] ctr_step(input logic [CTR_BITS-1:0] c, input logic up);
    if (up) return (c == '1) ? c : c + CTR_BITS'(1);
    else    return (c == '0) ? c : c - CTR_BITS'(1);
  endfunction

  function automatic logic [1:0] ch_step(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'd1;
    else    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  // Lookup reads the current (pre-update) tables; a same-cycle update is not bypassed.
  always_comb begin
    ci_w   = PC[IDX_BITS+1:2];
    gi_w   = ghr_q ^ PC[GHR_BITS+1:2];
    pi_w   = lht_q[ci_w] ^ PC[LHR_BITS+1:2];
    pg_w   = gpht_q[gi_w][CTR_BITS-1];
    pp_w   = ppht_q[pi_w][CTR_BITS-1];
    sel_w  = chooser_q[ci_w][1];
    pred_w = sel_w ? pg_w : pp_w;
    nex_w  = pred_w ? etiqueta : PC + n'(4);
  end

  // ready depends combinationally on upd_valid so a resolving branch frees the slot
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (valid) state_d = PEND;
      end
      PEND: begin
        ready = upd_valid;
        if (upd_valid) state_d = valid ? PEND : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign accept = valid & ready;
  assign do_upd = (state_q == PEND) & upd_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Prediction tables and histories, trained from the latched record
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < GHR_N; i++) gpht_q[i] <= CTR_INIT;
      for (int i = 0; i < LHR_N; i++) ppht_q[i] <= CTR_INIT;
      for (int i = 0; i < IDX_N; i++) begin
        chooser_q[i] <= 2'b01;
        lht_q[i]     <= '0;
      end
      ghr_q <= '0;
    end else if (do_upd) begin
      gpht_q[gi_q] <= ctr_step(gpht_q[gi_q], fix_result);
      ppht_q[pi_q] <= ctr_step(ppht_q[pi_q], fix_result);
      // Chooser only learns when the two components disagreed
      if (pg_q != pp_q) chooser_q[ci_q] <= ch_step(chooser_q[ci_q], pg_q == fix_result);
      ghr_q       <= {ghr_q[GHR_BITS-2:0], fix_result};
      lht_q[ci_q] <= {lht_q[ci_q][LHR_BITS-2:0], fix_result};
    end
  end

  // Lookup record and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ci_q         <= '0;
      gi_q         <= '0;
      pi_q         <= '0;
      pg_q         <= 1'b0;
      pp_q         <= 1'b0;
      pred_valid_q <= 1'b0;
      prediction_q <= 1'b0;
      nex_pc_q     <= '0;
      mispredict_q <= 1'b0;
    end else begin
      mispredict_q <= do_upd & (prediction_q != fix_result);
      if (accept) begin
        ci_q         <= ci_w;
        gi_q         <= gi_w;
        pi_q         <= pi_w;
        pg_q         <= pg_w;
        pp_q         <= pp_w;
        pred_valid_q <= 1'b1;
        prediction_q <= pred_w;
        nex_pc_q     <= nex_w;
      end else if (do_upd) begin
        pred_valid_q <= 1'b0;
      end
    end
  end

  assign pred_valid = pred_valid_q;
  assign prediction = prediction_q;
  assign nex_PC     = nex_pc_q;
  assign mispredict = mispredict_q;

`ifdef TOURN_STATS_EN
  logic [31:0] stat_lookups_q, stat_miss_q;

  // stat_miss advances on the same edge that raises the mispredict pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_lookups_q <= '0;
      stat_miss_q    <= '0;
    end else begin
      if (accept && stat_lookups_q != 32'hFFFF_FFFF) stat_lookups_q <= stat_lookups_q + 32'd1;
      if (do_upd && (prediction_q != fix_result) && stat_miss_q != 32'hFFFF_FFFF)
        stat_miss_q <= stat_miss_q + 32'd1;
    end
  end

  assign stat_lookups = stat_lookups_q;
  assign stat_miss    = stat_miss_q;
`endif

endmodule

// File: tb/tb_tournament_pred_pipe.sv
// tb/tb_tournament_pred_pipe.sv - self-checking bench for tournament_pred_pipe
module tb_tournament_pred_pipe;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] PC = '0;
  logic [31:0] etiqueta = '0;
  logic        upd_valid = 1'b0;
  logic        fix_result = 1'b0;
  logic        ready, pred_valid, prediction, mispredict;
  logic [31:0] nex_PC;
`ifdef TOURN_STATS_EN
  logic [31:0] stat_lookups, stat_miss;
`endif

  tournament_pred_pipe dut (
    .clock       (clock),
    .reset       (reset),
    .valid       (valid),
    .PC          (PC),
    .etiqueta    (etiqueta),
    .ready       (ready),
    .pred_valid  (pred_valid),
    .prediction  (prediction),
    .nex_PC      (nex_PC),
    .upd_valid   (upd_valid),
    .fix_result  (fix_result),
    .mispredict  (mispredict)
`ifdef TOURN_STATS_EN
    ,
    .stat_lookups(stat_lookups),
    .stat_miss   (stat_miss)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Reference model: tables as integer counters, indices from address arithmetic
  int          gp[16], pp[16], ch[16], lh[16];
  int          ghr;
  bit          m_pend, m_pv, m_pred, m_miss;
  logic [31:0] m_nex;
  int          r_ci, r_gi, r_pi;
  bit          r_pg, r_pp;
  int          m_look, m_misscnt;

  function automatic int sat(int c, bit up, int mx);
    if (up) return (c < mx) ? c + 1 : c;
    return (c > 0) ? c - 1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      gp[i] = 1; pp[i] = 1; ch[i] = 1; lh[i] = 0;
    end
    ghr = 0; m_pend = 0; m_pv = 0; m_pred = 0; m_miss = 0; m_nex = '0;
    r_ci = 0; r_gi = 0; r_pi = 0; r_pg = 0; r_pp = 0;
    m_look = 0; m_misscnt = 0;
  endtask

  task automatic model_step(input bit v, input logic [31:0] pc, input logic [31:0] tgt,
                            input bit uv, input bit fr);
    bit acc, upd, pg_n, pp_n, sel_n, pred_n;
    int ci, gi, pi, a;
    acc = v && (!m_pend || uv);
    upd = m_pend && uv;
    a   = int'((pc >> 2) & 32'd15);
    ci  = a; gi = ghr ^ a; pi = lh[ci] ^ a;
    pg_n = gp[gi] >= 2; pp_n = pp[pi] >= 2; sel_n = ch[ci] >= 2;
    pred_n = sel_n ? pg_n : pp_n;
    m_miss = upd && (m_pred != fr);
    if (m_miss) m_misscnt++;
    if (upd) begin
      gp[r_gi] = sat(gp[r_gi], fr, 3);
      pp[r_pi] = sat(pp[r_pi], fr, 3);
      if (r_pg != r_pp) ch[r_ci] = sat(ch[r_ci], r_pg == fr, 3);
      ghr = ((ghr * 2) + int'(fr)) % 16;
      lh[r_ci] = ((lh[r_ci] * 2) + int'(fr)) % 16;
    end
    if (acc) begin
      m_look++;
      r_ci = ci; r_gi = gi; r_pi = pi; r_pg = pg_n; r_pp = pp_n;
      m_pv = 1; m_pred = pred_n;
      m_nex = pred_n ? tgt : pc + 32'd4;
      m_pend = 1;
    end else if (upd) begin
      m_pv = 0; m_pend = 0;
    end
  endtask

  task automatic check_outs();
    check("pred_valid", {31'd0, pred_valid}, {31'd0, m_pv});
    check("mispredict", {31'd0, mispredict}, {31'd0, m_miss});
    if (m_pv) begin
      check("prediction", {31'd0, prediction}, {31'd0, m_pred});
      check("nex_PC", nex_PC, m_nex);
    end
`ifdef TOURN_STATS_EN
    check("stat_lookups", stat_lookups, m_look);
    check("stat_miss", stat_miss, m_misscnt);
`endif
  endtask

  // One clock: drive inputs, check ready, clock, advance model, check outputs
  task automatic cycle(input bit v, input logic [31:0] pc, input logic [31:0] tgt,
                       input bit uv, input bit fr);
    valid = v; PC = pc; etiqueta = tgt; upd_valid = uv; fix_result = fr;
    #1;
    check("ready", {31'd0, ready}, {31'd0, (!m_pend || uv)});
    @(posedge clock);
    model_step(v, pc, tgt, uv, fr);
    #1;
    check_outs();
  endtask

  task automatic apply_reset();
    valid = 0; upd_valid = 0;
    reset = 0;
    model_reset();
    @(posedge clock);
    #1;
    reset = 1;
  endtask

  bit exp_pred[6] = '{0, 0, 0, 0, 0, 1};

  initial begin
    model_reset();
    #12 reset = 1;
    #1;
    check("rst_pred_valid", {31'd0, pred_valid}, 32'd0);
    check("rst_prediction", {31'd0, prediction}, 32'd0);
    check("rst_nex_PC", nex_PC, 32'd0);
    check("rst_mispredict", {31'd0, mispredict}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd1);

    // Single lookup after reset
    cycle(1, 32'h100, 32'h200, 0, 0);
    check("t1_prediction", {31'd0, prediction}, 32'd0);
    check("t1_nex_PC", nex_PC, 32'h104);
    valid = 0;
    #1;
    check("t1_ready", {31'd0, ready}, 32'd0);

    // Six always-taken lookup/update pairs on the same PC
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      cycle(1, 32'h100, 32'h200, 0, 0);
      check("t2_pred_seq", {31'd0, prediction}, {31'd0, exp_pred[k]});
      cycle(0, 32'h0, 32'h0, 1, 1);
      check("t2_miss_seq", {31'd0, mispredict}, (k < 5) ? 32'd1 : 32'd0);
    end
    check("t2_last_nex", m_nex, 32'h200);
`ifdef TOURN_STATS_EN
    check("t6_lookups", stat_lookups, 32'd6);
    check("t6_miss", stat_miss, 32'd5);
`endif

    // Same-cycle resolve and new lookup
    apply_reset();
    cycle(1, 32'h100, 32'h200, 0, 0);
    cycle(1, 32'h104, 32'h300, 1, 1);
    check("t3_pred_valid", {31'd0, pred_valid}, 32'd1);
    check("t3_mispredict", {31'd0, mispredict}, 32'd1);
    check("t3_nex_PC", nex_PC, 32'h108);
    cycle(0, 32'h0, 32'h0, 1, 0);

    // Resolve while idle is ignored
    apply_reset();
    cycle(0, 32'h0, 32'h0, 1, 1);
    check("t4_no_miss", {31'd0, mispredict}, 32'd0);
    cycle(1, 32'h100, 32'h200, 0, 0);
    check("t4_prediction", {31'd0, prediction}, 32'd0);
    check("t4_nex_PC", nex_PC, 32'h104);

    // Address wrap, then asynchronous reset while a branch is in flight
    cycle(0, 32'h0, 32'h0, 1, 0);
    cycle(1, 32'hFFFF_FFFC, 32'h40, 0, 0);
    check("t5_wrap", nex_PC, 32'h0);
    #2 reset = 0;
    #1;
    check("t5_async_pv", {31'd0, pred_valid}, 32'd0);
    check("t5_async_pred", {31'd0, prediction}, 32'd0);
    check("t5_async_nex", nex_PC, 32'd0);
    model_reset();
    @(posedge clock);
    #1 reset = 1;
    #1;
    check("t5_ready_after", {31'd0, ready}, 32'd1);

    // Randomised traffic against the model
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      logic [31:0] pc;
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      cycle($urandom_range(0, 2) != 0, pc, $urandom, $urandom_range(0, 2) != 0, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
